// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
//  Data-memory responder for the CPU MA-stage port. Word-organised RAM with a
//  fixed multi-cycle access time; the pipeline is stalled through BUSYWAIT.
//  Handles byte/half/word stores and loads with sign/zero extension, and
//  flags misaligned accesses with a one-cycle MISALIGNED pulse.
//
//  Optional feature: define DMEM_LAST_WORD_BUF_EN to add a one-entry
//  last-word buffer that lets aligned loads to the most recently accessed
//  word complete after a single stall cycle.
//
// Parameters
//  DEPTH_WORDS     RAM depth in 32-bit words (power of 2)
//  ACCESS_LATENCY  cycles BUSYWAIT is high per access (>=1)
//
// Ports
//  CLK         in   1   clock, rising edge
//  RST         in   1   asynchronous active-high reset
//  ADDR        in   32  byte address
//  WRITE_DATA  in   32  store data, right-aligned
//  READ        in   4   [3]=load enable, [2:0]=funct3
//  WRITE       in   3   [2]=store enable, [1:0]=size
//  READ_DATA   out  32  extended load result (registered)
//  BUSYWAIT    out  1   stall request to the core
//  MISALIGNED  out  1   pulse in DONE when the completed access was misaligned
// ---------------------------------------------------------------------------
module data_memory_ctrl #(
    parameter int DEPTH_WORDS    = 256,
    parameter int ACCESS_LATENCY = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ADDR,
    input  logic [31:0] WRITE_DATA,
    input  logic [3:0]  READ,
    input  logic [2:0]  WRITE,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (ACCESS_LATENCY > 2) ? $clog2(ACCESS_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (ACCESS_LATENCY >= 2) ? CNT_W'(ACCESS_LATENCY - 2) : '0;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        mem [DEPTH_WORDS];

    logic               store_req, load_req, req;
    logic [IDX_W-1:0]   word_idx;
    logic               misaligned;
    logic [3:0]         lane_en;
    logic [31:0]        st_word, cur_word, merged_word, load_val;
    logic               fast_hit, do_access;
    logic               unused_addr_bits;

    function automatic logic [31:0] sext8(input logic signed [7:0] b);
        return 32'(b);
    endfunction

    function automatic logic [31:0] sext16(input logic signed [15:0] h);
        return 32'(h);
    endfunction

    function automatic logic [31:0] zext8(input logic [7:0] b);
        return {24'h0, b};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] h);
        return {16'h0, h};
    endfunction

    // A simultaneous load and store is handled purely as a store.
    assign store_req        = WRITE[2];
    assign load_req         = READ[3] & ~WRITE[2];
    assign req              = READ[3] | WRITE[2];
    assign word_idx         = ADDR[IDX_W+1:2];
    assign unused_addr_bits = ^ADDR[31:IDX_W+2];

    always_comb begin
        misaligned = 1'b0;
        if (store_req) begin
            case (WRITE[1:0])
                2'b01:   misaligned = ADDR[0];
                2'b10:   misaligned = |ADDR[1:0];
                default: misaligned = 1'b0;
            endcase
        end else if (READ[3]) begin
            case (READ[2:0])
                3'b001, 3'b101: misaligned = ADDR[0];
                3'b010:         misaligned = |ADDR[1:0];
                default:        misaligned = 1'b0;
            endcase
        end
    end

    // Store data is replicated across lanes so the lane enables alone pick
    // the destination bytes.
    always_comb begin
        lane_en = 4'b0000;
        st_word = WRITE_DATA;
        case (WRITE[1:0])
            2'b00: begin
                lane_en = 4'b0001 << ADDR[1:0];
                st_word = {4{WRITE_DATA[7:0]}};
            end
            2'b01: begin
                lane_en = ADDR[1] ? 4'b1100 : 4'b0011;
                st_word = {2{WRITE_DATA[15:0]}};
            end
            2'b10:   lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
        if (!store_req || misaligned)
            lane_en = 4'b0000;
    end

`ifdef DMEM_LAST_WORD_BUF_EN
    logic               buf_valid;
    logic [IDX_W-1:0]   buf_idx;
    logic [31:0]        buf_data;
    logic               buf_match;

    assign buf_match = buf_valid && (buf_idx == word_idx);
    assign fast_hit  = (state == IDLE) && load_req && !misaligned && buf_match;
    assign cur_word  = buf_match ? buf_data : mem[word_idx];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            buf_valid <= 1'b0;
        else if (do_access)
            buf_valid <= 1'b1;
    end

    // Buffer always mirrors the word as it stands after the access.
    always_ff @(posedge CLK) begin
        if (do_access && !RST) begin
            buf_idx  <= word_idx;
            buf_data <= merged_word;
        end
    end
`else
    assign fast_hit = 1'b0;
    assign cur_word = mem[word_idx];
`endif

    always_comb begin
        for (int i = 0; i < 4; i++)
            merged_word[8*i +: 8] = lane_en[i] ? st_word[8*i +: 8] : cur_word[8*i +: 8];
    end

    always_comb begin
        case (READ[2:0])
            3'b000:  load_val = sext8(cur_word[8*ADDR[1:0] +: 8]);
            3'b001:  load_val = sext16(ADDR[1] ? cur_word[31:16] : cur_word[15:0]);
            3'b010:  load_val = cur_word;
            3'b100:  load_val = zext8(cur_word[8*ADDR[1:0] +: 8]);
            3'b101:  load_val = zext16(ADDR[1] ? cur_word[31:16] : cur_word[15:0]);
            default: load_val = 32'h0;
        endcase
        if (misaligned)
            load_val = 32'h0;
    end

    // The access is performed on the edge that moves the FSM into DONE.
    assign do_access = ((state == ACCESS) && (cnt == '0)) ||
                       ((state == IDLE) && req && ((ACCESS_LATENCY == 1) || fast_hit));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE)
                cnt <= CNT_INIT;
            else if ((state == ACCESS) && (cnt != '0))
                cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = ((ACCESS_LATENCY == 1) || fast_hit) ? DONE : ACCESS;
            ACCESS:  if (cnt == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // BUSYWAIT is forced low while reset is held so an aborted access
    // releases the core immediately.
    always_comb begin
        BUSYWAIT = 1'b0;
        case (state)
            IDLE:    BUSYWAIT = req;
            ACCESS:  BUSYWAIT = 1'b1;
            default: BUSYWAIT = 1'b0;
        endcase
        if (RST)
            BUSYWAIT = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            READ_DATA  <= 32'h0;
            MISALIGNED <= 1'b0;
        end else begin
            MISALIGNED <= do_access & misaligned;
            if (do_access && load_req)
                READ_DATA <= load_val;
        end
    end

    // RAM contents are never reset.
    always_ff @(posedge CLK) begin
        if (do_access && !RST) begin
            for (int i = 0; i < 4; i++)
                if (lane_en[i])
                    mem[word_idx][8*i +: 8] <= st_word[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_memory_ctrl
//  Directed, table-driven bench for data_memory_ctrl (DEPTH_WORDS=256,
//  ACCESS_LATENCY=5), plus hand-written sequences for reset, abort and
//  back-to-back requests. Stall-length expectations follow the
//  DMEM_LAST_WORD_BUF_EN setting of the build.
// ---------------------------------------------------------------------------
module tb_data_memory_ctrl;

    localparam int LAT = 5;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] ADDR, WRITE_DATA;
    logic [3:0]  READ;
    logic [2:0]  WRITE;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT, MISALIGNED;

    int errors = 0;
    int checks = 0;

    // Reference tracking of the last-word buffer (only consulted when enabled).
    bit          bvalid = 1'b0;
    logic [7:0]  bidx   = 8'h0;

    always #5 CLK = ~CLK;

    data_memory_ctrl #(.DEPTH_WORDS(256), .ACCESS_LATENCY(LAT)) dut (
        .CLK(CLK), .RST(RST), .ADDR(ADDR), .WRITE_DATA(WRITE_DATA),
        .READ(READ), .WRITE(WRITE), .READ_DATA(READ_DATA),
        .BUSYWAIT(BUSYWAIT), .MISALIGNED(MISALIGNED)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] r, input logic [2:0] w,
                       input logic [31:0] ed, input logic em);
        vec_t v;
        v.name = n; v.addr = a; v.wdata = wd; v.rd = r; v.wr = w;
        v.exp_data = ed; v.exp_mis = em;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Expected stall length for a request, updating the buffer model.
    function automatic int exp_cycles(input logic [3:0] r, input logic [2:0] w,
                                      input logic [31:0] a, input logic mis);
        int c;
        c = LAT;
`ifdef DMEM_LAST_WORD_BUF_EN
        if (r[3] && !w[2] && !mis && bvalid && (bidx == a[9:2]))
            c = 1;
`endif
        bvalid = 1'b1;
        bidx   = a[9:2];
        return c;
    endfunction

    // Called just after a rising edge with the FSM idle. Returns in the DONE
    // cycle (at the falling edge) with the count of stall cycles seen.
    task automatic run_req(input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] r, input logic [2:0] w, input bit hold,
                           output int cyc, output logic [31:0] data, output logic mis);
        ADDR = a; WRITE_DATA = wd; READ = r; WRITE = w;
        cyc = 0;
        @(negedge CLK);
        while (BUSYWAIT === 1'b1 && cyc < 50) begin
            cyc++;
            @(negedge CLK);
        end
        data = READ_DATA;
        mis  = MISALIGNED;
        if (!hold) begin
            READ = 4'b0; WRITE = 3'b0;
        end
    endtask

    initial begin
        int          cyc, ec;
        logic [31:0] data;
        logic        mis;

        RST = 1'b1; ADDR = '0; WRITE_DATA = '0; READ = '0; WRITE = '0;

        //            name        addr        wdata        rd       wr       exp_data     mis
        add("sw_30",      32'h30,  32'hCAFEF00D, 4'b0000, 3'b110, 32'h00000000, 1'b0);
        add("sw_10",      32'h10,  32'hDEADBEEF, 4'b0000, 3'b110, 32'h00000000, 1'b0);
        add("lw_10",      32'h10,  32'h0,        4'b1010, 3'b000, 32'hDEADBEEF, 1'b0);
        add("sw_20_zero", 32'h20,  32'h0,        4'b0000, 3'b110, 32'hDEADBEEF, 1'b0);
        add("sb_21",      32'h21,  32'h80,       4'b0000, 3'b100, 32'hDEADBEEF, 1'b0);
        add("lb_21",      32'h21,  32'h0,        4'b1000, 3'b000, 32'hFFFFFF80, 1'b0);
        add("lbu_21",     32'h21,  32'h0,        4'b1100, 3'b000, 32'h00000080, 1'b0);
        add("lhu_20",     32'h20,  32'h0,        4'b1101, 3'b000, 32'h00008000, 1'b0);
        add("lh_20",      32'h20,  32'h0,        4'b1001, 3'b000, 32'hFFFF8000, 1'b0);
        add("sh_13_mis",  32'h13,  32'h1234,     4'b0000, 3'b101, 32'hFFFF8000, 1'b1);
        add("lw_10_kept", 32'h10,  32'h0,        4'b1010, 3'b000, 32'hDEADBEEF, 1'b0);
        add("sh_12",      32'h12,  32'hABCD,     4'b0000, 3'b101, 32'hDEADBEEF, 1'b0);
        add("lhu_12",     32'h12,  32'h0,        4'b1101, 3'b000, 32'h0000ABCD, 1'b0);
        add("lw_11_mis",  32'h11,  32'h0,        4'b1010, 3'b000, 32'h00000000, 1'b1);
        add("lw_10_sh",   32'h10,  32'h0,        4'b1010, 3'b000, 32'hABCDBEEF, 1'b0);
        add("ld_f3_011",  32'h10,  32'h0,        4'b1011, 3'b000, 32'h00000000, 1'b0);
        add("lw_wrap",    32'h410, 32'h0,        4'b1010, 3'b000, 32'hABCDBEEF, 1'b0);
        add("ld_st_both", 32'h10,  32'h55,       4'b1010, 3'b100, 32'hABCDBEEF, 1'b0);
        add("lbu_10",     32'h10,  32'h0,        4'b1100, 3'b000, 32'h00000055, 1'b0);
        add("lb_13",      32'h13,  32'h0,        4'b1000, 3'b000, 32'hFFFFFFAB, 1'b0);
        add("sb_33",      32'h33,  32'h7F,       4'b0000, 3'b100, 32'hFFFFFFAB, 1'b0);
        add("lh_32",      32'h32,  32'h0,        4'b1001, 3'b000, 32'h00007FFE, 1'b0);

        // Reset while idle
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busywait", {31'h0, BUSYWAIT}, 32'h0);
        check("rst_read_data", READ_DATA, 32'h0);
        check("rst_misaligned", {31'h0, MISALIGNED}, 32'h0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        foreach (vecs[i]) begin
            ec = exp_cycles(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].exp_mis);
            run_req(vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr, 1'b0, cyc, data, mis);
            check({vecs[i].name, "_cycles"}, 32'(cyc), 32'(ec));
            check({vecs[i].name, "_mis"}, {31'h0, mis}, {31'h0, vecs[i].exp_mis});
            check({vecs[i].name, "_data"}, data, vecs[i].exp_data);
            @(posedge CLK);
            #1;
            check({vecs[i].name, "_mis_pulse"}, {31'h0, MISALIGNED}, 32'h0);
        end

        // Request held through DONE: seen again only in the following cycle
        ec = exp_cycles(4'b1010, 3'b000, 32'h30, 1'b0);
        run_req(32'h30, 32'h0, 4'b1010, 3'b000, 1'b1, cyc, data, mis);
        check("hold_first_data", data, 32'h7FFEF00D);
        @(negedge CLK);
        check("hold_rearm_busywait", {31'h0, BUSYWAIT}, 32'h1);
        ec = exp_cycles(4'b1010, 3'b000, 32'h30, 1'b0);
        cyc = 1;
        @(negedge CLK);
        while (BUSYWAIT === 1'b1 && cyc < 50) begin
            cyc++;
            @(negedge CLK);
        end
        check("hold_second_cycles", 32'(cyc), 32'(ec));
        check("hold_second_data", READ_DATA, 32'h7FFEF00D);
        READ = 4'b0;
        @(posedge CLK);
        #1;

        // Reset in the 3rd ACCESS cycle of SW 0x11111111 @0x30
        ADDR = 32'h30; WRITE_DATA = 32'h11111111; WRITE = 3'b110; READ = 4'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        bvalid = 1'b0;
        #1;
        check("abort_busywait_now", {31'h0, BUSYWAIT}, 32'h0);
        @(posedge CLK);
        #1;
        check("abort_busywait_held", {31'h0, BUSYWAIT}, 32'h0);
        check("abort_read_data", READ_DATA, 32'h0);
        READ = 4'b0; WRITE = 3'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        ec = exp_cycles(4'b1010, 3'b000, 32'h30, 1'b0);
        run_req(32'h30, 32'h0, 4'b1010, 3'b000, 1'b0, cyc, data, mis);
        check("abort_lw_cycles", 32'(cyc), 32'(ec));
        check("abort_lw_old_value", data, 32'h7FFEF00D);
        @(posedge CLK);
        #1;

        // Load right after a store to the same word, then a load elsewhere
        ec = exp_cycles(4'b0000, 3'b110, 32'h10, 1'b0);
        run_req(32'h10, 32'h01020304, 4'b0000, 3'b110, 1'b0, cyc, data, mis);
        check("sw_10_again_cycles", 32'(cyc), 32'(ec));
        @(posedge CLK);
        #1;
        ec = exp_cycles(4'b1010, 3'b000, 32'h10, 1'b0);
        run_req(32'h10, 32'h0, 4'b1010, 3'b000, 1'b0, cyc, data, mis);
        check("lw_after_sw_cycles", 32'(cyc), 32'(ec));
        check("lw_after_sw_data", data, 32'h01020304);
        @(posedge CLK);
        #1;
        ec = exp_cycles(4'b1010, 3'b000, 32'h40, 1'b0);
        run_req(32'h40, 32'h0, 4'b1010, 3'b000, 1'b0, cyc, data, mis);
        check("lw_40_miss_cycles", 32'(cyc), 32'(ec));
        @(posedge CLK);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
